// File: rtl/system_qsys_nios2_oci_dct_packer_if.sv
// rtl/system_qsys_nios2_oci_dct_packer_if.sv - DCT atom input, frame output and monitor bundle
interface system_qsys_nios2_oci_dct_packer_if #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4,
  parameter int LOST_W = 8
);
  localparam int BUF_W = ATOM_W * ATOMS;

  logic              trc_on;
  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              flush;
  logic              ovf_clr;
  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT_W-1:0]  frame_count;
  logic              frame_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow;
  logic [LOST_W-1:0] lost_count;
  logic              busy;

  modport master (
    input  trc_on, atom_valid, atom, flush, ovf_clr, frame_ready,
    output frame_valid, frame_data, frame_count, dct_buffer, dct_count,
           overflow, lost_count, busy
  );

  modport slave (
    output trc_on, atom_valid, atom, flush, ovf_clr, frame_ready,
    input  frame_valid, frame_data, frame_count, dct_buffer, dct_count,
           overflow, lost_count, busy
  );
endinterface

// File: rtl/system_qsys_nios2_oci_dct_packer.sv
// rtl/system_qsys_nios2_oci_dct_packer.sv - packs 2-bit DCT atoms into 30-bit trace frames
module system_qsys_nios2_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4,
  parameter int LOST_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  system_qsys_nios2_oci_dct_packer_if.master bus
);
  localparam int BUF_W = ATOM_W * ATOMS;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(ATOMS);
  localparam logic [LOST_W-1:0] LOST_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [BUF_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              frame_valid_q;
  logic [BUF_W-1:0]  frame_data_q;
  logic [CNT_W-1:0]  frame_count_q;
  logic              overflow_q;
  logic [LOST_W-1:0] lost_q;

  logic              slot_free;
  logic              full;
  logic              xfer;
  logic              accept;
  logic              drop;
  logic [CNT_W-1:0]  base_cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic [BUF_W-1:0]  next_acc;

  // A transfer empties the accumulator first, so a same-cycle atom lands in slot 0.
  always_comb begin
    slot_free = !frame_valid_q | bus.frame_ready;
    full      = (cnt_q == FULL);
    xfer      = slot_free & (((state == RUN) & full) | ((state == DRAIN) & (cnt_q != '0)));
    accept    = (state == RUN) & bus.atom_valid & (!full | xfer);
    drop      = bus.atom_valid & (((state == RUN) & full & !slot_free) | (state == DRAIN));
    base_cnt  = xfer ? '0 : cnt_q;
    next_acc  = xfer ? '0 : acc_q;
    for (int i = 0; i < ATOMS; i++) begin
      if (accept && (base_cnt == CNT_W'(i))) begin
        next_acc[i*ATOM_W +: ATOM_W] = bus.atom;
      end
    end
    next_cnt = base_cnt + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      lost_q        <= '0;
    end else begin
      acc_q <= next_acc;
      cnt_q <= next_cnt;

      if (xfer) begin
        frame_valid_q <= 1'b1;
        frame_data_q  <= acc_q;
        frame_count_q <= cnt_q;
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_q <= 1'b0;
      end

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow_q <= 1'b1;
        if (bus.ovf_clr) begin
          lost_q <= LOST_W'(1);
        end else if (lost_q != LOST_MAX) begin
          lost_q <= lost_q + LOST_W'(1);
        end
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
        lost_q     <= '0;
      end

      // Decisions use the post-update count so DRAIN is never entered empty.
      case (state)
        IDLE: begin
          if (bus.trc_on) begin
            state <= RUN;
          end
        end
        RUN: begin
          if ((bus.flush || !bus.trc_on) && (next_cnt != '0)) begin
            state <= DRAIN;
          end else if (!bus.trc_on) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (xfer) begin
            state <= bus.trc_on ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_count = frame_count_q;
  assign bus.dct_buffer  = acc_q;
  assign bus.dct_count   = cnt_q;
  assign bus.overflow    = overflow_q;
  assign bus.lost_count  = lost_q;
  assign bus.busy        = (state != IDLE) | frame_valid_q;
endmodule

// File: tb/tb_system_qsys_nios2_oci_dct_packer.sv
// tb/tb_system_qsys_nios2_oci_dct_packer.sv - self-checking bench for the DCT packer
module tb_system_qsys_nios2_oci_dct_packer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  system_qsys_nios2_oci_dct_packer_if bus ();

  system_qsys_nios2_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: accumulator is a queue of atom codes, frame is a packed snapshot.
  int acc_q[$];
  bit m_run, m_drain, m_fv, m_ovf;
  int m_fd, m_fc, m_lost;

  typedef struct {
    bit rst_n, trc, av;
    int a;
    bit fl, clr, rdy;
    int e_cnt, e_fv, e_fd, e_fc, e_lost, e_busy;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack(input int q[$]);
    int v = 0;
    foreach (q[i]) v += q[i] * (1 << (2 * i));
    return v;
  endfunction

  task automatic emit();
    m_fd = pack(acc_q);
    m_fc = acc_q.size();
    m_fv = 1;
    acc_q.delete();
  endtask

  task automatic model_step();
    bit slot_free, emitted, dropped;
    if (!reset_n) begin
      acc_q.delete();
      m_run = 0; m_drain = 0; m_fv = 0; m_fd = 0; m_fc = 0; m_ovf = 0; m_lost = 0;
      return;
    end
    slot_free = !m_fv || bus.frame_ready;
    emitted = 0;
    dropped = 0;
    if (m_drain) begin
      if (bus.atom_valid) dropped = 1;
      if (slot_free) begin
        emit(); emitted = 1; m_drain = 0; m_run = bus.trc_on;
      end
    end else if (m_run) begin
      if (acc_q.size() == 15 && slot_free) begin
        emit(); emitted = 1;
      end
      if (bus.atom_valid) begin
        if (acc_q.size() < 15) acc_q.push_back(int'(bus.atom));
        else dropped = 1;
      end
      if ((bus.flush || !bus.trc_on) && acc_q.size() > 0) begin
        m_run = 0; m_drain = 1;
      end else if (!bus.trc_on) begin
        m_run = 0;
      end
    end else if (bus.trc_on) begin
      m_run = 1;
    end
    if (!emitted && m_fv && bus.frame_ready) m_fv = 0;
    if (dropped) begin
      m_ovf = 1;
      m_lost = bus.ovf_clr ? 1 : (m_lost < 255 ? m_lost + 1 : 255);
    end else if (bus.ovf_clr) begin
      m_ovf = 0; m_lost = 0;
    end
  endtask

  task automatic compare_model();
    check("model dct_count",   int'(bus.dct_count),   acc_q.size());
    check("model dct_buffer",  int'(bus.dct_buffer),  pack(acc_q));
    check("model frame_valid", int'(bus.frame_valid), int'(m_fv));
    check("model frame_data",  int'(bus.frame_data),  m_fd);
    check("model frame_count", int'(bus.frame_count), m_fc);
    check("model overflow",    int'(bus.overflow),    int'(m_ovf));
    check("model lost_count",  int'(bus.lost_count),  m_lost);
    check("model busy",        int'(bus.busy),        int'(m_run || m_drain || m_fv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_in(input bit trc, input bit av, input int a, input bit fl, input bit clr,
                        input bit rdy);
    bus.trc_on      = trc;
    bus.atom_valid  = av;
    bus.atom        = 2'(a);
    bus.flush       = fl;
    bus.ovf_clr     = clr;
    bus.frame_ready = rdy;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " frame_valid"}, int'(bus.frame_valid), 0);
    check({tag, " frame_data"},  int'(bus.frame_data),  0);
    check({tag, " frame_count"}, int'(bus.frame_count), 0);
    check({tag, " dct_buffer"},  int'(bus.dct_buffer),  0);
    check({tag, " dct_count"},   int'(bus.dct_count),   0);
    check({tag, " overflow"},    int'(bus.overflow),    0);
    check({tag, " lost_count"},  int'(bus.lost_count),  0);
    check({tag, " busy"},        int'(bus.busy),        0);
  endtask

  initial begin
    int atoms[$];
    int q[$];

    // Flush/drain and trc_on-off sequences with hand-derived expectations.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0,       0, 0, 1};
    tbl[1]  = '{1, 1, 1, 3, 0, 0, 1, 1, 0, 0,       0, 0, 1};
    tbl[2]  = '{1, 1, 1, 2, 0, 0, 1, 2, 0, 0,       0, 0, 1};
    tbl[3]  = '{1, 1, 1, 1, 0, 0, 1, 3, 0, 0,       0, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 1, 0, 1, 3, 0, 0,       0, 0, 1};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 'h1B,    3, 1, 1};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 'h1B,    3, 1, 1};
    tbl[7]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 'h1B,    3, 0, 1};
    tbl[8]  = '{1, 1, 1, 2, 0, 0, 1, 1, 0, 'h1B,    3, 0, 1};
    tbl[9]  = '{1, 1, 1, 2, 0, 0, 1, 2, 0, 'h1B,    3, 0, 1};
    tbl[10] = '{1, 1, 1, 2, 0, 0, 1, 3, 0, 'h1B,    3, 0, 1};
    tbl[11] = '{1, 1, 1, 2, 0, 0, 1, 4, 0, 'h1B,    3, 0, 1};
    tbl[12] = '{1, 1, 1, 2, 0, 0, 1, 5, 0, 'h1B,    3, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 5, 0, 'h1B,    3, 0, 1};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 'h2AA,   5, 0, 1};
    tbl[15] = '{1, 0, 1, 3, 0, 0, 1, 0, 0, 'h2AA,   5, 0, 0};
    tbl[16] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 'h2AA,   5, 0, 0};

    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n;
      set_in(tbl[i].trc, tbl[i].av, tbl[i].a, tbl[i].fl, tbl[i].clr, tbl[i].rdy);
      tick();
      check($sformatf("vec%0d dct_count", i),   int'(bus.dct_count),   tbl[i].e_cnt);
      check($sformatf("vec%0d frame_valid", i), int'(bus.frame_valid), tbl[i].e_fv);
      check($sformatf("vec%0d frame_data", i),  int'(bus.frame_data),  tbl[i].e_fd);
      check($sformatf("vec%0d frame_count", i), int'(bus.frame_count), tbl[i].e_fc);
      check($sformatf("vec%0d lost_count", i),  int'(bus.lost_count),  tbl[i].e_lost);
      check($sformatf("vec%0d busy", i),        int'(bus.busy),        tbl[i].e_busy);
    end

    // Full frame, back-to-back atoms 1,2,3,0,...
    set_in(1, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 1, (i + 1) % 4, 0, 0, 1);
      tick();
    end
    check("full dct_count", int'(bus.dct_count), 15);
    check("full early valid", int'(bus.frame_valid), 0);
    set_in(1, 0, 0, 0, 0, 1);
    tick();
    check("full frame_valid", int'(bus.frame_valid), 1);
    check("full frame_data", int'(bus.frame_data), 'h39393939);
    check("full frame_count", int'(bus.frame_count), 15);
    tick();
    check("full valid one cycle", int'(bus.frame_valid), 0);
    check("full lost_count", int'(bus.lost_count), 0);

    // Back-pressure: 32 atoms with the writer stalled.
    for (int i = 0; i < 32; i++) begin
      atoms.push_back(int'($urandom_range(0, 3)));
      set_in(1, 1, atoms[i], 0, 0, 0);
      tick();
    end
    check("bp overflow", int'(bus.overflow), 1);
    check("bp lost_count", int'(bus.lost_count), 2);
    check("bp dct_count", int'(bus.dct_count), 15);
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(atoms[i]);
    check("bp frame1 data", int'(bus.frame_data), pack(q));
    set_in(1, 0, 0, 0, 0, 1);
    tick();
    q.delete();
    for (int i = 15; i < 30; i++) q.push_back(atoms[i]);
    check("bp frame2 valid", int'(bus.frame_valid), 1);
    check("bp frame2 data", int'(bus.frame_data), pack(q));
    tick();
    check("bp drained", int'(bus.frame_valid), 0);

    // Reset mid-fill, then reset with a frame pending.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1, i % 4, 0, 0, 1);
      tick();
    end
    check("mid dct_count", int'(bus.dct_count), 7);
    reset_n = 1'b0;
    tick();
    check_all_zero("mid reset");
    reset_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, 3, 0, 0, 0);
      tick();
    end
    check("pend frame_valid", int'(bus.frame_valid), 1);
    reset_n = 1'b0;
    tick();
    check_all_zero("pend reset");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1);
      tick();
      check("no frame after reset", int'(bus.frame_valid), 0);
    end

    // Saturation of lost_count and clear racing a drop.
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 30 + 256; i++) begin
      set_in(1, 1, 1, 0, 0, 0);
      tick();
    end
    check("sat lost_count", int'(bus.lost_count), 255);
    check("sat overflow", int'(bus.overflow), 1);
    set_in(1, 1, 1, 0, 1, 0);
    tick();
    check("clr+drop overflow", int'(bus.overflow), 1);
    check("clr+drop lost_count", int'(bus.lost_count), 1);
    set_in(1, 0, 0, 0, 1, 0);
    tick();
    check("clr overflow", int'(bus.overflow), 0);
    check("clr lost_count", int'(bus.lost_count), 0);

    // Random traffic against the queue model.
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 24) == 0) bus.trc_on = ~bus.trc_on;
      bus.atom_valid  = ($urandom_range(0, 9) < 7);
      bus.atom        = 2'($urandom_range(0, 3));
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.ovf_clr     = ($urandom_range(0, 39) == 0);
      bus.frame_ready = ($urandom_range(0, 9) < 5);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
